// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one memory port.
// Grant one cycle after request; requester ack one cycle after mem_ack; requesters hold req until acked.
`ifndef WIDTH
`define WIDTH 128
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module mem_arbiter #(
    parameter int WIDTH  = `WIDTH,
    parameter int ADDR_W = `REG_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_mem_read_req,
    input  logic [ADDR_W-1:0] ic_mem_read_addr,
    output logic [WIDTH-1:0]  ic_mem_read_data,
    output logic              ic_mem_read_ack,
    input  logic              dc_mem_read_req,
    input  logic [ADDR_W-1:0] dc_mem_read_addr,
    output logic [WIDTH-1:0]  dc_mem_read_data,
    output logic              dc_mem_read_ack,
    input  logic              dc_mem_write_req,
    input  logic [ADDR_W-1:0] dc_mem_write_addr,
    input  logic [WIDTH-1:0]  dc_mem_write_data,
    output logic              dc_mem_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_data_in,
    input  logic [WIDTH-1:0]  mem_data_out,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic [1:0] {G_IC_RD, G_DC_RD, G_DC_WR} grant_t;

    state_t              r_state;
    state_t              w_state_nxt;
    grant_t              r_grant;
    grant_t              w_grant_sel;
    logic                r_last_dc;
    logic                w_ic_pend;
    logic                w_dc_pend;
    logic                w_pick_dc;
    logic                w_any_pend;
    logic [ADDR_W-1:0]   w_addr_sel;

    logic                r_mem_enable;
    logic                r_mem_rw;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WIDTH-1:0]    r_mem_data_in;
    logic [WIDTH-1:0]    r_ic_data;
    logic [WIDTH-1:0]    r_dc_data;
    logic                r_ic_ack;
    logic                r_dc_rd_ack;
    logic                r_dc_wr_ack;

    // Within the D-cache a writeback beats its refill so the dirty line lands first.
    // Between caches, the side not served last wins a tie.
    always_comb begin
        w_ic_pend   = ic_mem_read_req;
        w_dc_pend   = dc_mem_read_req | dc_mem_write_req;
        w_any_pend  = w_ic_pend | w_dc_pend;
        w_pick_dc   = w_dc_pend & (~w_ic_pend | ~r_last_dc);
        w_grant_sel = G_IC_RD;
        w_addr_sel  = ic_mem_read_addr;
        if (w_pick_dc) begin
            if (dc_mem_write_req) begin
                w_grant_sel = G_DC_WR;
                w_addr_sel  = dc_mem_write_addr;
            end else begin
                w_grant_sel = G_DC_RD;
                w_addr_sel  = dc_mem_read_addr;
            end
        end

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_pend) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_ack) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= G_IC_RD;
            r_last_dc     <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_ic_data     <= '0;
            r_dc_data     <= '0;
            r_ic_ack      <= 1'b0;
            r_dc_rd_ack   <= 1'b0;
            r_dc_wr_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ic_ack    <= 1'b0;
            r_dc_rd_ack <= 1'b0;
            r_dc_wr_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_pend) begin
                        r_grant       <= w_grant_sel;
                        r_last_dc     <= w_pick_dc;
                        r_mem_enable  <= 1'b1;
                        r_mem_rw      <= (w_grant_sel == G_DC_WR);
                        r_mem_addr    <= w_addr_sel;
                        r_mem_data_in <= (w_grant_sel == G_DC_WR) ? dc_mem_write_data : '0;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_mem_enable <= 1'b0;
                        case (r_grant)
                            G_IC_RD: begin
                                r_ic_data <= mem_data_out;
                                r_ic_ack  <= 1'b1;
                            end
                            G_DC_RD: begin
                                r_dc_data   <= mem_data_out;
                                r_dc_rd_ack <= 1'b1;
                            end
                            G_DC_WR: r_dc_wr_ack <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_enable       = r_mem_enable;
    assign mem_rw           = r_mem_rw;
    assign mem_addr         = r_mem_addr;
    assign mem_data_in      = r_mem_data_in;
    assign ic_mem_read_data = r_ic_data;
    assign ic_mem_read_ack  = r_ic_ack;
    assign dc_mem_read_data = r_dc_data;
    assign dc_mem_read_ack  = r_dc_rd_ack;
    assign dc_mem_write_ack = r_dc_wr_ack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache, the data cache and the synchronous main memory. It accepts line-refill reads from `Icache`, plus line reads and dirty-line writebacks from `Dcache`. It serialises them onto one `mem_enable`/`mem_rw`/`mem_ack` memory port and returns line data and a one-cycle ack to the requester. It sits directly downstream of both cache instances in `cpu` and directly upstream of `memory_sync`.

## Interface
- `WIDTH`, default `` `WIDTH ``: cache line / memory data width in bits.
- `ADDR_W`, default `` `REG_SIZE `` (32): memory address width.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `ic_mem_read_req` in 1: I-cache refill request; held until acked.
- `ic_mem_read_addr` in ADDR_W: I-cache line address.
- `ic_mem_read_data` out WIDTH: refill line for I-cache; registered.
- `ic_mem_read_ack` out 1: one-cycle pulse, data valid.
- `dc_mem_read_req` in 1: D-cache refill request.
- `dc_mem_read_addr` in ADDR_W: D-cache read line address.
- `dc_mem_read_data` out WIDTH: refill line for D-cache; registered.
- `dc_mem_read_ack` out 1: one-cycle pulse.
- `dc_mem_write_req` in 1: D-cache writeback request.
- `dc_mem_write_addr` in ADDR_W: writeback line address.
- `dc_mem_write_data` in WIDTH: writeback line.
- `dc_mem_write_ack` out 1: one-cycle pulse, write committed.
- `mem_enable` out 1: memory transaction active.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: latched transaction address.
- `mem_data_in` out WIDTH: write data to memory.
- `mem_data_out` in WIDTH: read data from memory; valid with `mem_ack`.
- `mem_ack` in 1: memory completion; single-cycle pulse.

## Operation
- States: IDLE, BUSY, RESP. A 2-bit grant register records the source: IC_RD, DC_RD or DC_WR. A 1-bit `last_dc` fairness flag records whether the last grant was to the D-cache.
- IDLE, arbitration among pending requests:
  - D-cache side: write beats read, so a dirty writeback always precedes the refill of the same set.
  - I-cache vs D-cache: if only one side is pending, it wins. If both are pending, the side not served last wins: I wins if `last_dc`=1, D wins otherwise.
- On grant:
  - Latch address, `mem_rw` and write data into output registers; set `mem_enable`=1; go to BUSY.
  - Update `last_dc` to 1 for DC_RD/DC_WR and 0 for IC_RD.
- BUSY:
  - Hold `mem_enable`, `mem_rw`, `mem_addr` and `mem_data_in` stable. Request inputs are not re-sampled.
  - On `mem_ack`=1: clear `mem_enable`. For a read, load `mem_data_out` into the granted requester's data register. Raise that requester's ack. Go to RESP.
- RESP: exactly one ack is high for this one cycle, then go to IDLE. The next arbitration happens in IDLE, never in RESP.
- Requester contract: deassert req at the edge that samples ack. The arbiter therefore never sees a stale req in the IDLE cycle after RESP.
- `mem_ack` in IDLE or RESP is ignored.
- A request dropped before its grant is simply lost; no error is raised.
- Data registers hold their last value until overwritten by the next read to the same requester. The other requester's data register is untouched.
- `mem_data_in` is 0 whenever `mem_rw`=0.

## Timing
- Reset values:
  - State = IDLE, `last_dc`=0, grant = IC_RD.
  - `mem_enable`=0, `mem_rw`=0, `mem_addr`=0, `mem_data_in`=0.
  - All acks 0; both data registers 0.
- Reset during BUSY or RESP aborts the transaction. `mem_enable` and all acks are 0 in the cycle after the reset edge, and no ack is issued for the aborted request.
- Request high in IDLE during cycle N gives `mem_enable`=1 in cycle N+1.
- Memory acks in cycle N+1+L, with L ≥ 0 (L=0 means ack in the same cycle enable first rises).
- Requester ack and data are valid in cycle N+2+L; the arbiter is back in IDLE in N+3+L.
- Minimum turnaround is 3 cycles per transaction.
- Back-to-back pending requests: the second is granted in the IDLE cycle after RESP, so one dead cycle separates transactions.
- Simultaneous I and D requests with `last_dc`=0: D is granted first and I is granted next.

## Test plan
- Single I-cache read, addr 0x0000_0040, memory returns 0xA5 pattern with L=2 -> `mem_enable`/`mem_rw`=0 cycles 1–3, `ic_mem_read_ack` pulse at cycle 4 with data 0xA5…, no D ack.
- D writeback addr 0x100, data 0x1234… -> `mem_rw`=1, `mem_data_in`=0x1234… stable through BUSY, `dc_mem_write_ack` single pulse, `dc_mem_read_data` unchanged.
- I read and D read asserted same cycle after reset -> D served first, then I. Repeat with both requesters re-requesting continuously -> grants alternate D, I, D, I.
- D write and D read pending together plus I read, `last_dc`=0 -> order DC_WR, IC_RD, DC_RD.
- Reset asserted mid-BUSY, L=5 -> `mem_enable`=0 next cycle, no ack emitted, late `mem_ack` ignored, fresh I request then served normally.
- Spurious `mem_ack` pulses in IDLE and RESP -> no state change, no extra ack pulses.
